mem_access_stage: RTL and testbench

- Memory-access pipeline stage sitting between the ALU stage and writeback.
- Registers the ALU result and performs load/store transactions on a req/ack data-memory port.
- Drives the bypass signals consumed by the operand forwarding unit: rd address, rd data, reg write-enable, stage ce and data-valid.
- Holds valid low while a load is outstanding, so the forwarding unit stalls dependent instructions instead of forwarding stale data.

---
 rtl/mem_access_stage_pkg.sv | 42 ++++
 rtl/mem_access_stage_if.sv | 17 +
 rtl/mem_access_stage_load_store_align.sv | 57 +++++
 rtl/mem_access_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 access codes, FSM states,
// strobe width and the misalignment helper used when MISALIGN_TRAP_EN is defined.
package mem_access_stage_pkg;

  localparam int STRB_W = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  // Half accesses need an even address, word-sized (and unknown-size) accesses a multiple of four.
  function automatic logic is_misaligned(input logic is_load, input logic [2:0] funct3,
                                         input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_LB, F3_LBU: mis = 1'b0;
        F3_LH, F3_LHU: mis = lane[0];
        default:       mis = (lane != 2'b00);
      endcase
    end else begin
      case (funct3)
        F3_SB:   mis = 1'b0;
        F3_SH:   mis = lane[0];
        default: mis = (lane != 2'b00);
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_stage_if #(
  parameter int DWIDTH  = 32,
  parameter int MAWIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [MAWIDTH-1:0]    addr;
  logic [DWIDTH-1:0]     wdata;
  logic [DWIDTH/8-1:0]   wstrb;
  logic                  ack;
  logic [DWIDTH-1:0]     rdata;

  modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/mem_access_stage_load_store_align.sv
// Byte-lane steering: store data replication/strobes and load sign/zero extension.
// Purely combinational so a cache front-end can reuse it unchanged.
module load_store_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_lane,
  input  logic [31:0]       st_data,
  output logic [31:0]       st_wdata,
  output logic [STRB_W-1:0] st_wstrb,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_lane,
  input  logic [31:0]       ld_rdata,
  output logic [31:0]       ld_data
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Store lane generation; low address bits below the access size are ignored.
  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (st_funct3)
      F3_SB: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_lane;
      end
      F3_SH: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << {st_lane[1], 1'b0};
      end
      default: begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane selection and extension; unknown funct3 behaves as a full word.
  always_comb begin
    ld_byte_s = ld_rdata[{ld_lane, 3'b000} +: 8];
    if (ld_lane[1]) begin
      ld_half_s = ld_rdata[31:16];
    end else begin
      ld_half_s = ld_rdata[15:0];
    end
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
      F3_LH:   ld_data = {{16{ld_half_s[15]}}, ld_half_s};
      F3_LBU:  ld_data = {24'd0, ld_byte_s};
      F3_LHU:  ld_data = {16'd0, ld_half_s};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: registers ALU results, runs loads/stores on a req/ack
// port and drives forwarding bypass signals. Optional macro: MISALIGN_TRAP_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 5,
  parameter int MAWIDTH = 32
) (
  input  logic               h_clk,
  input  logic               h_rst_n,
  input  logic               h_i_alu_ce,
  input  logic [AWIDTH-1:0]  h_i_alu_addr_rd,
  input  logic [DWIDTH-1:0]  h_i_alu_data_rd,
  input  logic               h_i_we_reg,
  input  logic               h_i_is_load,
  input  logic               h_i_is_store,
  input  logic [2:0]         h_i_funct3,
  input  logic [DWIDTH-1:0]  h_i_store_data,
  input  logic               h_i_stall,
  input  logic               h_i_flush,
  output logic               h_o_stall,
  output logic               h_o_ce,
  output logic               h_o_valid,
  output logic               h_o_we_reg,
  output logic [AWIDTH-1:0]  h_o_addr_rd,
  output logic [DWIDTH-1:0]  h_o_data_rd,
`ifdef MISALIGN_TRAP_EN
  output logic               h_o_misaligned,
`endif
  mem_access_stage_if.master mem
);

  state_t                state_r;
  logic                  ce_r, valid_r, we_reg_r, flush_pend_r, is_load_r;
  logic [AWIDTH-1:0]     addr_rd_r;
  logic [DWIDTH-1:0]     data_rd_r;
  logic                  mem_req_r, mem_we_r;
  logic [MAWIDTH-1:0]    mem_addr_r;
  logic [DWIDTH-1:0]     mem_wdata_r;
  logic [STRB_W-1:0]     mem_wstrb_r;
  logic [2:0]            funct3_r;
  logic [1:0]            lane_r;
`ifdef MISALIGN_TRAP_EN
  logic                  misaligned_r;
`endif

  logic                  accept_s, mem_op_s, store_s, trap_s;
  logic [DWIDTH-1:0]     st_wdata_s, ld_data_s;
  logic [STRB_W-1:0]     st_wstrb_s;

  assign accept_s = (state_r == ST_IDLE) && h_i_alu_ce && !h_i_stall && !h_i_flush;
  assign mem_op_s = h_i_is_load || h_i_is_store;
  // A simultaneous load and store flag is resolved as a load.
  assign store_s  = h_i_is_store && !h_i_is_load;
`ifdef MISALIGN_TRAP_EN
  assign trap_s   = is_misaligned(!store_s, h_i_funct3, h_i_alu_data_rd[1:0]);
`else
  assign trap_s   = 1'b0;
`endif

  load_store_align u_align (
    .st_funct3 (h_i_funct3),
    .st_lane   (h_i_alu_data_rd[1:0]),
    .st_data   (h_i_store_data),
    .st_wdata  (st_wdata_s),
    .st_wstrb  (st_wstrb_s),
    .ld_funct3 (funct3_r),
    .ld_lane   (lane_r),
    .ld_rdata  (mem.rdata),
    .ld_data   (ld_data_s)
  );

  // Stage FSM with all bypass and memory-port outputs registered.
  always_ff @(posedge h_clk or negedge h_rst_n) begin
    if (!h_rst_n) begin
      state_r      <= ST_IDLE;
      ce_r         <= 1'b0;
      valid_r      <= 1'b0;
      we_reg_r     <= 1'b0;
      flush_pend_r <= 1'b0;
      is_load_r    <= 1'b0;
      addr_rd_r    <= {AWIDTH{1'b0}};
      data_rd_r    <= {DWIDTH{1'b0}};
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {MAWIDTH{1'b0}};
      mem_wdata_r  <= {DWIDTH{1'b0}};
      mem_wstrb_r  <= {STRB_W{1'b0}};
      funct3_r     <= 3'b000;
      lane_r       <= 2'b00;
`ifdef MISALIGN_TRAP_EN
      misaligned_r <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_TRAP_EN
      misaligned_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            ce_r         <= 1'b1;
            addr_rd_r    <= h_i_alu_addr_rd;
            data_rd_r    <= h_i_alu_data_rd;
            flush_pend_r <= 1'b0;
            if (mem_op_s && trap_s) begin
              valid_r      <= 1'b1;
              we_reg_r     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
              misaligned_r <= 1'b1;
`endif
            end else if (mem_op_s) begin
              state_r     <= ST_WAIT_ACK;
              mem_req_r   <= 1'b1;
              mem_we_r    <= store_s;
              mem_addr_r  <= {h_i_alu_data_rd[MAWIDTH-1:2], 2'b00};
              mem_wdata_r <= st_wdata_s;
              mem_wstrb_r <= store_s ? st_wstrb_s : {STRB_W{1'b0}};
              valid_r     <= store_s;
              we_reg_r    <= store_s ? 1'b0 : h_i_we_reg;
              is_load_r   <= !store_s;
              funct3_r    <= h_i_funct3;
              lane_r      <= h_i_alu_data_rd[1:0];
            end else begin
              valid_r  <= 1'b1;
              we_reg_r <= h_i_we_reg;
            end
          end else if (h_i_flush || !h_i_stall) begin
            ce_r     <= 1'b0;
            valid_r  <= 1'b0;
            we_reg_r <= 1'b0;
          end else begin
            ce_r <= ce_r;
          end
        end
        ST_WAIT_ACK: begin
          if (mem.ack) begin
            state_r      <= ST_IDLE;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            flush_pend_r <= 1'b0;
            if (flush_pend_r || h_i_flush) begin
              ce_r     <= 1'b0;
              valid_r  <= 1'b0;
              we_reg_r <= 1'b0;
            end else if (is_load_r) begin
              data_rd_r <= ld_data_s;
              valid_r   <= 1'b1;
            end else begin
              valid_r <= 1'b1;
            end
          end else if (h_i_flush) begin
            // The bus transaction must still finish; only the result is squashed.
            flush_pend_r <= 1'b1;
            we_reg_r     <= 1'b0;
          end else begin
            mem_req_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign h_o_stall   = (state_r == ST_WAIT_ACK) || h_i_stall;
  assign h_o_ce      = ce_r;
  assign h_o_valid   = valid_r;
  assign h_o_we_reg  = we_reg_r;
  assign h_o_addr_rd = addr_rd_r;
  assign h_o_data_rd = data_rd_r;
  assign mem.req     = mem_req_r;
  assign mem.we      = mem_we_r;
  assign mem.addr    = mem_addr_r;
  assign mem.wdata   = mem_wdata_r;
  assign mem.wstrb   = mem_wstrb_r;
`ifdef MISALIGN_TRAP_EN
  assign h_o_misaligned = misaligned_r;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// transactions against a byte-level reference model.
module tb_mem_access_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        alu_ce, we_reg, is_load, is_store, stall, flush;
  logic [4:0]  addr_rd;
  logic [31:0] alu_data, store_data;
  logic [2:0]  funct3;
  logic        o_stall, o_ce, o_valid, o_we_reg;
  logic [4:0]  o_addr_rd;
  logic [31:0] o_data_rd;
`ifdef MISALIGN_TRAP_EN
  logic        o_misaligned;
`endif

  mem_access_stage_if #(.DWIDTH(32), .MAWIDTH(32)) mem_bus ();

  mem_access_stage #(.DWIDTH(32), .AWIDTH(5), .MAWIDTH(32)) dut (
    .h_clk           (clk),
    .h_rst_n         (rst_n),
    .h_i_alu_ce      (alu_ce),
    .h_i_alu_addr_rd (addr_rd),
    .h_i_alu_data_rd (alu_data),
    .h_i_we_reg      (we_reg),
    .h_i_is_load     (is_load),
    .h_i_is_store    (is_store),
    .h_i_funct3      (funct3),
    .h_i_store_data  (store_data),
    .h_i_stall       (stall),
    .h_i_flush       (flush),
    .h_o_stall       (o_stall),
    .h_o_ce          (o_ce),
    .h_o_valid       (o_valid),
    .h_o_we_reg      (o_we_reg),
    .h_o_addr_rd     (o_addr_rd),
    .h_o_data_rd     (o_data_rd),
`ifdef MISALIGN_TRAP_EN
    .h_o_misaligned  (o_misaligned),
`endif
    .mem             (mem_bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  wire [39:0] stage_obs = {o_ce, o_valid, o_we_reg, o_addr_rd, o_data_rd};
  wire [69:0] mem_obs   = {mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata, mem_bus.wstrb};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_ce = 1'b0; we_reg = 1'b0; is_load = 1'b0; is_store = 1'b0;
    stall = 1'b0; flush = 1'b0; addr_rd = 5'd0; alu_data = 32'd0;
    store_data = 32'd0; funct3 = 3'd0;
    mem_bus.ack = 1'b0; mem_bus.rdata = 32'd0;
  endtask

  // Reference: access size in bytes from funct3.
  function automatic int acc_bytes(input logic ld, input logic [2:0] f3);
    if (f3 == 3'd0 || (ld && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (ld && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lane,
                                           input logic [31:0] rd);
    logic [31:0] v;
    int n;
    n = acc_bytes(1'b1, f3);
    if (n == 4) return rd;
    v = (rd >> (8 * ((lane / n) * n))) & ((32'd1 << (8 * n)) - 32'd1);
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= (32'd1 << (8 * n - 1)))
      v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int n;
    n = acc_bytes(1'b0, f3);
    w = 32'd0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input int lane);
    int n;
    n = acc_bytes(1'b0, f3);
    return 4'(((1 << n) - 1) << ((lane / n) * n));
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({stage_obs, mem_obs, o_stall} !== 111'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got stage=%h mem=%h stall=%b, want all 0", stage_obs, mem_obs, o_stall);
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    alu_ce = 1'b1; addr_rd = 5'd5; alu_data = 32'h0000_0010; we_reg = 1'b1;
    step();
    clear_inputs();
    n_tests++;
    if ({stage_obs, mem_bus.req} !== {1'b1, 1'b1, 1'b1, 5'd5, 32'h0000_0010, 1'b0}) begin
      n_fail++;
      $display("FAIL alu_add: got stage=%h req=%b, want 3,05,00000010 req=0", stage_obs, mem_bus.req);
    end
    step();
    n_tests++;
    if ({o_ce, o_valid, o_we_reg} !== 3'b000) begin
      n_fail++;
      $display("FAIL alu_idle_clear: got %b, want 000", {o_ce, o_valid, o_we_reg});
    end
  endtask

  task automatic test_load_lb();
    alu_ce = 1'b1; is_load = 1'b1; funct3 = 3'b000; alu_data = 32'h0000_0103;
    addr_rd = 5'd7; we_reg = 1'b1;
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({o_ce, o_valid, o_stall, mem_bus.req, mem_bus.we, mem_bus.addr} !==
          {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100}) begin
        n_fail++;
        $display("FAIL lb_wait[%0d]: ce=%b valid=%b stall=%b req=%b we=%b addr=%h, want 1 0 1 1 0 00000100",
                 i, o_ce, o_valid, o_stall, mem_bus.req, mem_bus.we, mem_bus.addr);
      end
      if (i < 2) step();
    end
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'h80AA_BBCC;
    step();
    clear_inputs();
    n_tests++;
    if ({o_data_rd, o_valid, o_ce, o_we_reg, mem_bus.req, o_stall} !==
        {32'hFFFF_FF80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL lb_result: data=%h valid=%b ce=%b we=%b req=%b stall=%b, want ffffff80 1 1 1 0 0",
               o_data_rd, o_valid, o_ce, o_we_reg, mem_bus.req, o_stall);
    end
    step();
  endtask

  task automatic test_store_sh();
    alu_ce = 1'b1; is_store = 1'b1; funct3 = 3'b001; alu_data = 32'h0000_0202;
    store_data = 32'h1234_ABCD; addr_rd = 5'd9; we_reg = 1'b1;
    step();
    clear_inputs();
    n_tests++;
    if ({mem_obs, o_we_reg, o_valid, o_ce} !==
        {1'b1, 1'b1, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sh_issue: mem=%h we_reg=%b valid=%b ce=%b, want req1 we1 00000200 abcdabcd 1100 0 1 1",
               mem_obs, o_we_reg, o_valid, o_ce);
    end
    mem_bus.ack = 1'b1;
    step();
    clear_inputs();
    n_tests++;
    if ({mem_bus.req, o_stall, o_valid, o_we_reg} !== 4'b0010) begin
      n_fail++;
      $display("FAIL sh_done: req=%b stall=%b valid=%b we=%b, want 0 0 1 0",
               mem_bus.req, o_stall, o_valid, o_we_reg);
    end
    step();
  endtask

  task automatic test_flush_wait();
    alu_ce = 1'b1; is_load = 1'b1; funct3 = 3'b101; alu_data = 32'h0000_0044;
    addr_rd = 5'd11; we_reg = 1'b1;
    step();
    clear_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_tests++;
    if ({mem_bus.req, o_we_reg, o_ce, o_stall} !== 4'b1011) begin
      n_fail++;
      $display("FAIL flush_wait: req=%b we=%b ce=%b stall=%b, want 1 0 1 1", mem_bus.req, o_we_reg, o_ce, o_stall);
    end
    step();
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'h0000_F00F;
    step();
    clear_inputs();
    n_tests++;
    if ({o_ce, o_we_reg, o_valid, mem_bus.req} !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_done: ce=%b we=%b valid=%b req=%b, want 0000", o_ce, o_we_reg, o_valid, mem_bus.req);
    end
  endtask

  task automatic test_stall_hold();
    logic [39:0] held;
    alu_ce = 1'b1; addr_rd = 5'd3; alu_data = 32'hDEAD_BEEF; we_reg = 1'b1;
    step();
    held = {1'b1, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF};
    stall = 1'b1; addr_rd = 5'd4; alu_data = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({stage_obs, o_stall, mem_bus.req} !== {held, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: stage=%h stall=%b req=%b, want %h 1 0", i, stage_obs, o_stall, mem_bus.req, held);
      end
    end
    stall = 1'b0;
    step();
    clear_inputs();
    n_tests++;
    if (stage_obs !== {1'b1, 1'b1, 1'b1, 5'd4, 32'h1111_2222}) begin
      n_fail++;
      $display("FAIL stall_release: stage=%h, want 3 04 11112222", stage_obs);
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    alu_ce = 1'b1; is_load = 1'b1; funct3 = 3'b010; alu_data = 32'h0000_0300;
    addr_rd = 5'd2; we_reg = 1'b1;
    step();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({stage_obs, mem_obs, o_stall} !== 111'd0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: stage=%h mem=%h stall=%b, want all 0", stage_obs, mem_obs, o_stall);
    end
    step();
    rst_n = 1'b1;
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'h5555_5555;
    step();
    clear_inputs();
    n_tests++;
    if ({o_ce, o_valid, mem_bus.req, o_stall, o_data_rd} !== {4'b0000, 32'd0}) begin
      n_fail++;
      $display("FAIL late_ack_ignored: ce=%b valid=%b req=%b stall=%b data=%h, want 0 0 0 0 0",
               o_ce, o_valid, mem_bus.req, o_stall, o_data_rd);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      logic        ld, st, wr, do_flush, flushed, exp_we;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] ad, sd, rdata;
      int          dly, fl_cyc, lane;
      ld = 1'($urandom); st = 1'($urandom); wr = 1'($urandom);
      f3 = 3'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 31));
      ad = $urandom; sd = $urandom; rdata = $urandom;
      dly = $urandom_range(0, 3); fl_cyc = $urandom_range(0, 3);
      do_flush = ($urandom_range(0, 3) == 0);
      lane = int'(ad[1:0]);
      alu_ce = 1'b1; is_load = ld; is_store = st; we_reg = wr; funct3 = f3;
      addr_rd = rd; alu_data = ad; store_data = sd;
      step();
      clear_inputs();
      if (!ld && !st) begin
        n_tests++;
        if ({stage_obs, mem_bus.req} !== {1'b1, 1'b1, wr, rd, ad, 1'b0}) begin
          n_fail++;
          $display("FAIL rnd_alu[%0d]: stage=%h req=%b, want 1 1 %b %h %h 0", t, stage_obs, mem_bus.req, wr, rd, ad);
        end
      end else begin
        exp_we = ld ? wr : 1'b0;
        n_tests++;
        if ({o_ce, o_valid, o_we_reg, mem_bus.req, mem_bus.we, mem_bus.addr} !==
            {1'b1, !ld, exp_we, 1'b1, !ld, ad & 32'hFFFF_FFFC}) begin
          n_fail++;
          $display("FAIL rnd_issue[%0d]: ce=%b valid=%b we=%b req=%b mwe=%b addr=%h ld=%b",
                   t, o_ce, o_valid, o_we_reg, mem_bus.req, mem_bus.we, mem_bus.addr, ld);
        end
        if (!ld) begin
          n_tests++;
          if ({mem_bus.wdata, mem_bus.wstrb} !== {ref_wdata(f3, sd), ref_wstrb(f3, lane)}) begin
            n_fail++;
            $display("FAIL rnd_store_lanes[%0d]: wdata=%h wstrb=%b want %h %b",
                     t, mem_bus.wdata, mem_bus.wstrb, ref_wdata(f3, sd), ref_wstrb(f3, lane));
          end
        end
        flushed = 1'b0;
        for (int c = 0; c <= dly; c++) begin
          if (do_flush && c == fl_cyc) begin
            flush = 1'b1;
            flushed = 1'b1;
          end
          if (c == dly) begin
            mem_bus.ack = 1'b1;
            mem_bus.rdata = rdata;
          end
          step();
          flush = 1'b0; mem_bus.ack = 1'b0;
          n_tests++;
          if (c < dly) begin
            if ({mem_bus.req, o_stall, o_we_reg, mem_bus.addr} !==
                {1'b1, 1'b1, flushed ? 1'b0 : exp_we, ad & 32'hFFFF_FFFC}) begin
              n_fail++;
              $display("FAIL rnd_wait[%0d.%0d]: req=%b stall=%b we=%b addr=%h", t, c,
                       mem_bus.req, o_stall, o_we_reg, mem_bus.addr);
            end
          end else if ({o_ce, o_valid, o_we_reg, mem_bus.req, o_stall} !==
                       (flushed ? 5'b00000 : {1'b1, 1'b1, exp_we, 2'b00})) begin
            n_fail++;
            $display("FAIL rnd_ack[%0d]: ce=%b valid=%b we=%b req=%b stall=%b flushed=%b",
                     t, o_ce, o_valid, o_we_reg, mem_bus.req, o_stall, flushed);
          end
        end
        if (ld && !flushed) begin
          n_tests++;
          if (o_data_rd !== ref_load(f3, lane, rdata)) begin
            n_fail++;
            $display("FAIL rnd_load_data[%0d]: got %h want %h (f3=%0d lane=%0d rdata=%h)",
                     t, o_data_rd, ref_load(f3, lane, rdata), f3, lane, rdata);
          end
        end
      end
      step();
      n_tests++;
      if ({o_ce, o_valid, o_we_reg, o_stall} !== 4'b0000) begin
        n_fail++;
        $display("FAIL rnd_idle[%0d]: ce=%b valid=%b we=%b stall=%b", t, o_ce, o_valid, o_we_reg, o_stall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_lb();
    test_store_sh();
    test_flush_wait();
    test_stall_hold();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
